cva6_regfile_lvt_fpga: RTL and testbench
========================================

Name: cva6_regfile_lvt_fpga

Overview:
- Generalised FPGA register file: one distributed-RAM bank per write port, each bank with NR_READ_PORTS read ports.
- A live-value table (LVT) records which bank holds the newest copy of each entry, and the output mux selects that bank.
- Over the previous generation it adds parametric depth, selectable read latency (async or registered with write-first forwarding), and a sequential init/flush sweep that zeroes contents without a RAM reset.
- Used as the integer or FP register file of the CVA6 issue stage on FPGA targets.

Parameters:
- NUM_WORDS, 32, number of entries; power of two, >=2; ADDR_WIDTH = $clog2(NUM_WORDS).
- DATA_WIDTH, 64, bits per entry.
- NR_READ_PORTS, 2, number of read ports.
- NR_WRITE_PORTS, 2, number of write ports (= RAM banks); >=1.
- READ_LATENCY, 0, 0 = combinational read; 1 = registered read with same-cycle write forwarding.
- ZERO_REG_ZERO, 0, 1 = entry 0 is never written and always reads 0.
- LVT_WIDTH (derived), max(1, $clog2(NR_WRITE_PORTS)).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  restart the zeroing sweep (single-cycle pulse).
- init_busy_o  out  1  high while the zeroing sweep runs.
- raddr_i  in  NR_READ_PORTS x ADDR_WIDTH  read addresses.
- rdata_o  out  NR_READ_PORTS x DATA_WIDTH  read data.
- waddr_i  in  NR_WRITE_PORTS x ADDR_WIDTH  write addresses.
- wdata_i  in  NR_WRITE_PORTS x DATA_WIDTH  write data.
- we_i  in  NR_WRITE_PORTS  write enables.

Behaviour:
- Reset values (async assert):
  - FSM = INIT, sweep counter cnt = 0, all LVT entries = 0.
  - init_busy_o = 1.
  - Registered read data (READ_LATENCY=1) = 0.
  - RAM contents are not reset.
- FSM INIT:
  - Each cycle writes 0 to bank 0 entry cnt, sets LVT[cnt] = 0, then cnt++.
  - When cnt = NUM_WORDS-1 has been written, the next state is IDLE and init_busy_o falls.
  - init_busy_o is therefore high for exactly NUM_WORDS cycles after reset release.
  - we_i is ignored in INIT.
- FSM IDLE:
  - flush_i = 1 -> INIT with cnt = 0; init_busy_o is high from the next cycle.
  - A write presented in the same cycle as flush_i is performed.
- flush_i during INIT restarts the sweep with cnt = 0.
- Writes (IDLE only):
  - Port j writes bank j at waddr_i[j] when we_i[j] and !(ZERO_REG_ZERO && waddr_i[j] == 0).
  - The same condition sets LVT[waddr_i[j]] = j.
  - If several ports write the same address in one cycle, the highest port index wins in the LVT. Other banks may also be updated, but they are not read.
- Read, READ_LATENCY = 0:
  - rdata_o[k] = bank[LVT_q[raddr_i[k]]][raddr_i[k]], combinational.
  - A write in the current cycle is not visible; the value before the write is returned.
- Read, READ_LATENCY = 1:
  - Address sampled at edge N; data valid from edge N until edge N+1.
  - Write-first: if a qualifying write to the same address occurs in the sampling cycle, rdata_o returns that wdata. With several such writes, the highest port index wins.
  - Implementation: a synchronous RAM read plus per-bank forward registers, with the LVT read using the registered address.
- ZERO_REG_ZERO = 1: any read of address 0 returns 0 in both latency modes (in latency 1, from the registered address).
- While init_busy_o = 1, every rdata_o reads 0, including the registered output.
- Mid-operation reset: the sweep aborts and restarts after release; no partial state survives in the LVT.
- No combinational path from we_i/wdata_i to rdata_o in latency-0 mode.

Test Plan:
- Reset release, NUM_WORDS=32 -> init_busy_o high for 32 cycles then 0; every rdata_o reads 0 for all addresses afterwards.
- Latency 0, 2 write ports: port0 writes addr 5 = 0xAA, port1 writes addr 5 = 0xBB in the same cycle -> next cycle read addr 5 = 0xBB. Then port0 alone writes 0xCC -> addr 5 reads 0xCC (LVT now selects bank 0).
- Latency 1: present raddr=7 in the same cycle port1 writes addr 7 = 0x1234 -> rdata_o = 0x1234 one cycle later. Repeat with no write -> old value returned.
- ZERO_REG_ZERO=1: write addr 0 = 0xFFFF -> read addr 0 returns 0. LVT[0] is unchanged and bank 0 entry 0 still holds 0.
- Write addr 3 = 0x55, then pulse flush_i -> init_busy_o high for 32 cycles; writes during the sweep are ignored; afterwards addr 3 reads 0.
- Assert rst_ni low at sweep cnt=10 -> init_busy_o stays 1; after release it stays high a full 32 cycles.

Source files
------------

// File: rtl/cva6_regfile_lvt_fpga.sv
// Multi-write-port FPGA register file: one RAM bank per write port, a live-value
// table picks the newest bank per entry, and a sequential sweep zeroes contents.
module cva6_regfile_lvt_fpga #(
  parameter int unsigned NUM_WORDS      = 32,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned ZERO_REG_ZERO  = 0,
  localparam int unsigned ADDR_WIDTH    = $clog2(NUM_WORDS),
  localparam int unsigned LVT_WIDTH     = (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  init_busy_o,
  input  logic [ADDR_WIDTH-1:0] raddr_i [NR_READ_PORTS],
  output logic [DATA_WIDTH-1:0] rdata_o [NR_READ_PORTS],
  input  logic [ADDR_WIDTH-1:0] waddr_i [NR_WRITE_PORTS],
  input  logic [DATA_WIDTH-1:0] wdata_i [NR_WRITE_PORTS],
  input  logic [NR_WRITE_PORTS-1:0] we_i
);

  typedef enum logic [0:0] {INIT = 1'b0, IDLE = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic [LVT_WIDTH-1:0]  lvt_q [NUM_WORDS];
  logic [LVT_WIDTH-1:0]  lvt_d [NUM_WORDS];

  logic [DATA_WIDTH-1:0] mem_q [NR_WRITE_PORTS][NUM_WORDS];

  logic [NR_WRITE_PORTS-1:0] wq_s;
  logic [NR_WRITE_PORTS-1:0] bank_we_s;
  logic [ADDR_WIDTH-1:0]     bank_waddr_s [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]     bank_wdata_s [NR_WRITE_PORTS];

  assign init_busy_o = busy_q;

  // Qualify user writes: address 0 is read-only when it is hardwired to zero.
  always_comb begin
    for (int j = 0; j < NR_WRITE_PORTS; j++) begin
      if ((ZERO_REG_ZERO != 0) && (waddr_i[j] == ADDR_WIDTH'(0))) begin
        wq_s[j] = 1'b0;
      end else begin
        wq_s[j] = we_i[j];
      end
    end
  end

  // Sweep/idle control, LVT update and per-bank write port selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    lvt_d   = lvt_q;
    for (int b = 0; b < NR_WRITE_PORTS; b++) begin
      bank_we_s[b]    = 1'b0;
      bank_waddr_s[b] = waddr_i[b];
      bank_wdata_s[b] = wdata_i[b];
    end
    case (state_q)
      INIT: begin
        bank_we_s[0]    = 1'b1;
        bank_waddr_s[0] = cnt_q;
        bank_wdata_s[0] = {DATA_WIDTH{1'b0}};
        lvt_d[cnt_q]    = {LVT_WIDTH{1'b0}};
        if (flush_i) begin
          cnt_d = ADDR_WIDTH'(0);
        end else if (cnt_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = ADDR_WIDTH'(0);
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        // Ascending loop: the highest writing port index ends up in the LVT.
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
          if (wq_s[j]) begin
            bank_we_s[j]        = 1'b1;
            lvt_d[waddr_i[j]]   = LVT_WIDTH'(j);
          end else begin
            bank_we_s[j] = 1'b0;
          end
        end
        if (flush_i) begin
          state_d = INIT;
          cnt_d   = ADDR_WIDTH'(0);
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = ADDR_WIDTH'(0);
        busy_d  = 1'b1;
      end
    endcase
  end

  // Control and LVT state; the LVT is cleared on reset so no stale bank choice survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= ADDR_WIDTH'(0);
      busy_q  <= 1'b1;
      for (int i = 0; i < NUM_WORDS; i++) begin
        lvt_q[i] <= {LVT_WIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      lvt_q   <= lvt_d;
    end
  end

  // RAM banks carry no reset so they map onto distributed RAM.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NR_WRITE_PORTS; b++) begin
      if (bank_we_s[b]) begin
        mem_q[b][bank_waddr_s[b]] <= bank_wdata_s[b];
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_lat0
    // Asynchronous read through the LVT; only registered state feeds rdata_o.
    always_comb begin
      for (int k = 0; k < NR_READ_PORTS; k++) begin
        if (busy_q || ((ZERO_REG_ZERO != 0) && (raddr_i[k] == ADDR_WIDTH'(0)))) begin
          rdata_o[k] = {DATA_WIDTH{1'b0}};
        end else begin
          rdata_o[k] = mem_q[lvt_q[raddr_i[k]]][raddr_i[k]];
        end
      end
    end
  end else begin : g_lat1
    logic [ADDR_WIDTH-1:0] raddr_q [NR_READ_PORTS];
    logic [DATA_WIDTH-1:0] rd_q [NR_WRITE_PORTS][NR_READ_PORTS];
    logic [DATA_WIDTH-1:0] rd_d [NR_WRITE_PORTS][NR_READ_PORTS];

    // Per-bank synchronous read with write-first forwarding from that bank's write port.
    always_comb begin
      for (int b = 0; b < NR_WRITE_PORTS; b++) begin
        for (int k = 0; k < NR_READ_PORTS; k++) begin
          if (bank_we_s[b] && (bank_waddr_s[b] == raddr_i[k])) begin
            rd_d[b][k] = bank_wdata_s[b];
          end else begin
            rd_d[b][k] = mem_q[b][raddr_i[k]];
          end
        end
      end
    end

    // Read address and bank read registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < NR_READ_PORTS; k++) begin
          raddr_q[k] <= ADDR_WIDTH'(0);
          for (int b = 0; b < NR_WRITE_PORTS; b++) begin
            rd_q[b][k] <= {DATA_WIDTH{1'b0}};
          end
        end
      end else begin
        raddr_q <= raddr_i;
        rd_q    <= rd_d;
      end
    end

    // The LVT, already updated by the sampling-cycle write, picks the winning bank.
    always_comb begin
      for (int k = 0; k < NR_READ_PORTS; k++) begin
        if (busy_q || ((ZERO_REG_ZERO != 0) && (raddr_q[k] == ADDR_WIDTH'(0)))) begin
          rdata_o[k] = {DATA_WIDTH{1'b0}};
        end else begin
          rdata_o[k] = rd_q[lvt_q[raddr_q[k]]][k];
        end
      end
    end
  end

endmodule

// File: tb/tb_cva6_regfile_lvt_fpga.sv
// Directed bench: three instances (latency 0, latency 1, zero-register) share stimulus.
module tb_cva6_regfile_lvt_fpga;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  raddr [2];
  logic [4:0]  waddr [2];
  logic [63:0] wdata [2];
  logic [1:0]  we = 2'b00;
  logic [63:0] rd0 [2];
  logic [63:0] rd1 [2];
  logic [63:0] rd2 [2];
  logic        busy0, busy1, busy2;

  int n_total = 0;
  int n_pass  = 0;
  int n;

  always #5 clk = ~clk;

  cva6_regfile_lvt_fpga #(.READ_LATENCY(0), .ZERO_REG_ZERO(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .init_busy_o(busy0),
    .raddr_i(raddr), .rdata_o(rd0), .waddr_i(waddr), .wdata_i(wdata), .we_i(we));

  cva6_regfile_lvt_fpga #(.READ_LATENCY(1), .ZERO_REG_ZERO(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .init_busy_o(busy1),
    .raddr_i(raddr), .rdata_o(rd1), .waddr_i(waddr), .wdata_i(wdata), .we_i(we));

  cva6_regfile_lvt_fpga #(.READ_LATENCY(0), .ZERO_REG_ZERO(1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .init_busy_o(busy2),
    .raddr_i(raddr), .rdata_o(rd2), .waddr_i(waddr), .wdata_i(wdata), .we_i(we));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic count_busy(input string tag);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      tick();
    end
    chk(tag, 64'(n), 64'd32);
    chk({tag, "_all_idle"}, {61'd0, busy0, busy1, busy2}, 64'd0);
  endtask

  initial begin
    raddr[0] = 5'd0; raddr[1] = 5'd0;
    waddr[0] = 5'd0; waddr[1] = 5'd0;
    wdata[0] = 64'd0; wdata[1] = 64'd0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("reset_busy", {61'd0, busy0, busy1, busy2}, 64'h7);
    chk("reset_rd0", rd0[0], 64'd0);
    chk("reset_rd1", rd1[0], 64'd0);
    rst_n = 1'b1;
    count_busy("init_len");

    for (int a = 0; a < 32; a++) begin
      raddr[0] = 5'(a);
      raddr[1] = 5'(31 - a);
      tick();
      chk($sformatf("zero_a%0d", a), rd0[0] | rd0[1] | rd1[0] | rd1[1] | rd2[0] | rd2[1], 64'd0);
    end

    // Both ports write address 5 in one cycle; the old value is visible until the edge.
    raddr[0] = 5'd5; raddr[1] = 5'd6;
    waddr[0] = 5'd5; wdata[0] = 64'hAA;
    waddr[1] = 5'd5; wdata[1] = 64'hBB;
    we = 2'b11;
    #1;
    chk("lat0_pre_write", rd0[0], 64'd0);
    tick();
    we = 2'b00;
    #1;
    chk("lat0_dual_write", rd0[0], 64'hBB);
    chk("lat1_dual_fwd", rd1[0], 64'hBB);

    waddr[0] = 5'd5; wdata[0] = 64'hCC; we = 2'b01;
    #1;
    chk("lat0_before_cc", rd0[0], 64'hBB);
    tick();
    we = 2'b00;
    #1;
    chk("lat0_bank0_cc", rd0[0], 64'hCC);
    chk("lat1_bank0_fwd", rd1[0], 64'hCC);

    // Latency 1 forwarding and one-cycle address-to-data latency.
    raddr[0] = 5'd7;
    waddr[1] = 5'd7; wdata[1] = 64'h1234; we = 2'b10;
    tick();
    we = 2'b00;
    #1;
    chk("lat1_fwd_1234", rd1[0], 64'h1234);
    tick();
    chk("lat1_hold_1234", rd1[0], 64'h1234);
    chk("lat0_read_1234", rd0[0], 64'h1234);
    raddr[0] = 5'd8;
    #1;
    chk("lat1_not_yet", rd1[0], 64'h1234);
    tick();
    chk("lat1_addr8", rd1[0], 64'd0);

    // Address 0 is hardwired to zero only in dut2.
    waddr[0] = 5'd0; wdata[0] = 64'hFFFF; we = 2'b01;
    tick();
    we = 2'b00;
    raddr[0] = 5'd0; raddr[1] = 5'd5;
    #1;
    chk("zz_addr0", rd2[0], 64'd0);
    chk("nozz_addr0", rd0[0], 64'hFFFF);
    chk("zz_addr5", rd2[1], 64'hCC);

    waddr[1] = 5'd3; wdata[1] = 64'h55; we = 2'b10;
    tick();
    we = 2'b00;
    raddr[0] = 5'd3;
    #1;
    chk("pre_flush_3", rd0[0], 64'h55);

    // Flush: writes held during the sweep must be ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {61'd0, busy0, busy1, busy2}, 64'h7);
    chk("flush_rd_masked", rd0[0] | rd1[0] | rd2[1], 64'd0);
    waddr[0] = 5'd3; wdata[0] = 64'h77;
    waddr[1] = 5'd3; wdata[1] = 64'h88;
    we = 2'b11;
    count_busy("flush_len");
    we = 2'b00;
    raddr[0] = 5'd3; raddr[1] = 5'd5;
    #1;
    chk("post_flush_3", rd0[0], 64'd0);
    chk("post_flush_5", rd0[1], 64'd0);
    tick();
    chk("post_flush_lat1_3", rd1[0], 64'd0);

    // Reset in the middle of a sweep, after fresh data in bank 1.
    waddr[1] = 5'd7; wdata[1] = 64'h4321; we = 2'b10;
    tick();
    we = 2'b00;
    raddr[0] = 5'd7;
    #1;
    chk("pre_rst_7", rd0[0], 64'h4321);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {61'd0, busy0, busy1, busy2}, 64'h7);
    tick(); tick();
    chk("midrst_busy_hold", {61'd0, busy0, busy1, busy2}, 64'h7);
    rst_n = 1'b1;
    count_busy("midrst_len");
    raddr[0] = 5'd7;
    #1;
    chk("post_rst_7", rd0[0], 64'd0);
    tick();
    chk("post_rst_lat1_7", rd1[0], 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
